instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage: owns the program counter, issues single-outstanding word reads to instruction memory, and presents `{pc, instr, valid}` to the decode stage, which feeds the immediate generator and decoder. Honours downstream stall and branch/jump redirect, including responses that are in flight when a redirect arrives. A one-entry pending buffer absorbs a response that lands while decode is stalled.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: word address, always equal to the internal PC.
- `imem_gnt` in 1: request accepted this cycle; ignored when `imem_req`=0.
- `imem_rvalid` in 1: read data valid. Exactly one pulse per granted request, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: branch/jump resolved taken; flush and refetch.
- `redirect_pc` in 32: target; bits [1:0] are cleared internally.
- `stall` in 1: decode cannot accept; hold outputs.
- `if_valid` out 1: output triple valid.
- `if_pc` out 32: PC of `if_instr`.
- `if_instr` out 32: fetched instruction.

## Operation
- **States:** FETCH, WAIT, KILL. Registers:
  - `pc_q`
  - `req_pc`
  - `pend_valid/pend_pc/pend_instr`
  - output register `if_*`
- **Reset:**
  - state=FETCH, `pc_q`=RESET_PC.
  - `if_valid`=0, `if_pc`=0, `if_instr`=32'h0000_0013 (NOP).
  - `pend_valid`=0, `imem_req`=0 during the reset cycle.
- `accept = !if_valid || !stall`.
- **FETCH:**
  - `imem_req = !pend_valid && !redirect_valid`.
  - On req&&gnt: `req_pc<=pc_q`, `pc_q<=pc_q+4` (mod 2^32, so FFFF_FFFC→0000_0000), go to WAIT.
- **WAIT:** on `imem_rvalid`:
  - If `accept && !pend_valid`: `if_*<={1, req_pc, rdata}`.
  - Otherwise load pend with the same data.
  - Then go to FETCH.
  - No new request is issued in the response cycle, so peak throughput is 1 instruction per 2 cycles with 1-cycle memory.
- **Pend drain:** any cycle with `pend_valid && accept`: `if_*<=pend`, `pend_valid<=0`. FETCH then resumes requests next cycle.
- **Output consumption:** when `accept && nothing new to load`: `if_valid<=0`.
- **KILL:** wait for `imem_rvalid`, discard the data, go to FETCH.
- **Redirect (highest priority, any state, overrides stall):**
  - `pc_q<=redirect_pc&~3`, `if_valid<=0`, `pend_valid<=0`.
  - If state=WAIT and no rvalid this cycle → KILL.
  - If rvalid in the same cycle → data dropped, go to FETCH.
  - In KILL: stay KILL, pc updated.
  - In FETCH: request suppressed that cycle.
- **Invariants:**
  - Never more than one outstanding request; the pend buffer therefore never overflows.
  - `if_*` is unchanged while `stall && if_valid && !redirect_valid`.

## Timing
- 1-cycle-latency memory, no stall: req/gnt at cycle N, rvalid at N+1, `if_valid` at N+2, next req at N+2.
- Redirect at cycle N → first request to target at N+1 (from FETCH), or the cycle after the killed response returns.
- `imem_addr`/`imem_req` are combinational from state, `pc_q`, `pend_valid` and `redirect_valid`. All other outputs are registered.
- Reset asserted mid-WAIT: state returns to FETCH. The outstanding response is not tracked and the memory model must be reset with the core.

## Structure
- Shared package `fetch_pkg`:
  - state enum {FETCH, WAIT, KILL}
  - `NOP_INSTR` = 32'h0000_0013
  - `INSTR_BYTES` = 4
  - default RESET_PC constant
- One sub-module: `fetch_pend_buf`, a one-entry valid/pc/instr holding register with load/drain/flush. The FSM and PC stay in `instr_fetch`.

## Test plan
1. **Reset / straight-line:** RESET_PC=0x100, 1-cycle memory, no stall → `if_pc` sequence 0x100, 0x104, 0x108 with `if_valid` every 2nd cycle; first `if_valid` 2 cycles after first grant.
2. **Stall skid:** stall high while `if_valid`=1 and a response to 0x104 arrives → response lands in pend, `imem_req`=0. Stall low → `if_pc`=0x104 next cycle, then a request issues.
3. **Redirect in WAIT:** redirect to 0x2002 before rvalid → `if_valid`=0 immediately. Next response dropped (never shown). Next `imem_addr`=0x2000, then `if_pc`=0x2000.
4. **Redirect coincident with rvalid:** data discarded, state FETCH, request to target next cycle.
5. **Wrap:** redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
6. **Backpressured grant:** `imem_gnt`=0 for 3 cycles → `imem_req` and `imem_addr` held stable, PC not advanced.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: the fetch FSM state
// encoding, the NOP used as the idle output instruction, the instruction
// size used to step the PC, the default reset PC and a PC alignment helper.
// ---------------------------------------------------------------------------
package fetch_pkg;

    // FETCH: may issue a request.
    // WAIT:  one request outstanding, its data is wanted.
    // KILL:  one request outstanding, its data must be thrown away.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_pend_buf.sv
// ---------------------------------------------------------------------------
// fetch_pend_buf
// One-entry holding register for a fetched instruction that arrived while the
// decode stage could not take it.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   reset       in   synchronous active-high reset
//   flush       in   drop the held entry (redirect)
//   load        in   capture load_pc/load_instr as a valid entry
//   load_pc     in   PC of the instruction being captured
//   load_instr  in   instruction being captured
//   drain       in   the held entry has been moved downstream
//   pend_valid  out  entry holds an instruction
//   pend_pc     out  PC of the held instruction
//   pend_instr  out  held instruction
// ---------------------------------------------------------------------------
module fetch_pend_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        drain,
    output logic        pend_valid,
    output logic [31:0] pend_pc,
    output logic [31:0] pend_instr
);

    // Flush wins over everything. Load and drain never coincide because the
    // fetch FSM does not issue a request while the entry is occupied, so no
    // response can arrive while it is being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0000_0000;
            pend_instr <= NOP_INSTR;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_valid <= 1'b1;
            pend_pc    <= load_pc;
            pend_instr <= load_instr;
        end else if (drain) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. Owns the program counter, keeps at most one word
// read outstanding to instruction memory and hands {pc, instr, valid} to the
// decode stage. Handles decode stall through a one-entry pending buffer and
// branch/jump redirects, including dropping a response already in flight.
//
// Parameters:
//   RESET_PC        first PC fetched after reset
//
// Ports:
//   clk             in   clock, all state on the rising edge
//   reset           in   synchronous active-high reset
//   imem_req        out  read request valid
//   imem_addr       out  read address, always the current PC
//   imem_gnt        in   request accepted this cycle
//   imem_rvalid     in   read data valid, one pulse per granted request
//   imem_rdata      in   instruction word
//   redirect_valid  in   taken branch/jump: flush and refetch
//   redirect_pc     in   redirect target (low two bits ignored)
//   stall           in   decode cannot accept this cycle
//   if_valid        out  output triple valid
//   if_pc           out  PC of if_instr
//   if_instr        out  fetched instruction
// ---------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc;

    logic         pend_valid;
    logic [31:0]  pend_pc;
    logic [31:0]  pend_instr;

    logic         accept;
    logic         grant;
    logic         rsp_live;
    logic         rsp_to_out;
    logic         rsp_to_pend;
    logic         pend_drain;

    // Decode takes the current output if there is none or it is not stalling.
    assign accept = !if_valid || !stall;

    // Requests stop while the pending buffer is full (that is what keeps it
    // from overflowing) and in a redirect cycle, since pc_q is stale then.
    // Reset is included so nothing is requested during the reset cycle.
    assign imem_req  = !reset && (state == FETCH) && !pend_valid && !redirect_valid;
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response is only useful in WAIT and when no redirect is killing it.
    assign rsp_live    = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign rsp_to_out  = rsp_live && accept && !pend_valid;
    assign rsp_to_pend = rsp_live && !rsp_to_out;
    assign pend_drain  = pend_valid && accept && !redirect_valid;

    fetch_pend_buf u_pend (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .load       (rsp_to_pend),
        .load_pc    (req_pc),
        .load_instr (imem_rdata),
        .drain      (pend_drain),
        .pend_valid (pend_valid),
        .pend_pc    (pend_pc),
        .pend_instr (pend_instr)
    );

    // Fetch FSM and PC. A redirect overrides everything: the PC jumps to the
    // target and any request still outstanding is turned into a kill so its
    // data is dropped. A response arriving in the redirect cycle itself
    // closes the outstanding request, so the FSM can go straight to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            pc_q   <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
            case (state)
                WAIT, KILL: state <= imem_rvalid ? FETCH : KILL;
                default:    state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (grant) begin
                        req_pc <= pc_q;
                        pc_q   <= pc_q + INSTR_BYTES;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end
                end
                KILL: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Output register toward decode. A fresh response goes straight out when
    // decode can take it; otherwise a held pending entry is moved out. When
    // decode consumes the output and nothing replaces it, it goes invalid.
    // While stalled with valid output and no redirect, nothing here changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (rsp_to_out) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem_rdata;
        end else if (pend_drain) begin
            if_valid <= 1'b1;
            if_pc    <= pend_pc;
            if_instr <= pend_instr;
        end else if (accept) begin
            if_valid <= 1'b0;
        end
    end

endmodule
